// File: rtl/alu_bist.sv
// Self-test sequencer for the 32-bit ALU: plays a fixed 10-vector table into the
// ALU and scores each response against stored expectations.
module alu_bist #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  alu_control,
  input  logic [31:0] out_resultado,
  input  logic        zero,
  input  logic        carry_out,
  input  logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  first_fail_idx
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_VEC  = 10;
  localparam int unsigned CNT_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] NO_FAIL  = 4'hF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [3:0]       CNT_MAX  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        op;
    logic [DATA_W-1:0] res;
    logic              zf;
    logic              cf;
    logic              vf;
    logic              chk_flags;
  } vec_t;

  // Carry/overflow are only meaningful for the ADD vectors, so only those check them.
  function automatic vec_t vec_rom(input logic [IDX_W-1:0] i);
    vec_t v;
    v = '0;
    case (i)
      4'd0: begin v.op_a = 32'hFFFF0000; v.op_b = 32'h0F0F0F0F; v.op = 4'b0000; v.res = 32'h0F0F0000; end
      4'd1: begin v.op_a = 32'hFFFF0000; v.op_b = 32'h0F0F0F0F; v.op = 4'b0001; v.res = 32'hFFFF0F0F; end
      4'd2: begin v.op_a = 32'd100; v.op_b = 32'd50; v.op = 4'b0010; v.res = 32'd150; v.chk_flags = 1'b1; end
      4'd3: begin
        v.op_a = 32'h7FFFFFFF; v.op_b = 32'h00000001; v.op = 4'b0010; v.res = 32'h80000000;
        v.vf = 1'b1; v.chk_flags = 1'b1;
      end
      4'd4: begin
        v.op_a = 32'hFFFFFFFF; v.op_b = 32'h00000001; v.op = 4'b0010; v.res = 32'h00000000;
        v.zf = 1'b1; v.cf = 1'b1; v.chk_flags = 1'b1;
      end
      4'd5: begin v.op_a = 32'd200; v.op_b = 32'd150; v.op = 4'b0110; v.res = 32'd50; end
      4'd6: begin v.op_a = 32'd50; v.op_b = 32'd100; v.op = 4'b0110; v.res = 32'hFFFFFFCE; end
      4'd7: begin v.op_a = 32'd30; v.op_b = 32'd50; v.op = 4'b0111; v.res = 32'd1; end
      4'd8: begin v.op_a = 32'd50; v.op_b = 32'd30; v.op = 4'b0111; v.res = 32'd0; v.zf = 1'b1; end
      4'd9: begin
        v.op_a = 32'hAAAA5555; v.op_b = 32'h5555AAAA; v.op = 4'b1100; v.res = 32'h00000000;
        v.zf = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [CNT_W-1:0]  settle_cnt, settle_cnt_d;
  logic [DATA_W-1:0] a_d, b_d;
  logic [3:0]        alu_control_d;
  logic              busy_d, done_d, pass_d;
  logic [3:0]        fail_count_d, first_fail_idx_d;

  vec_t cur_vec, nxt_vec, first_vec;
  logic settle_last, sample, mismatch, last_vec;

  // Response scoring for the vector currently on the ALU inputs.
  always_comb begin
    cur_vec     = vec_rom(idx);
    nxt_vec     = vec_rom(IDX_W'(idx + 4'd1));
    first_vec   = vec_rom(4'd0);
    settle_last = (settle_cnt == CNT_W'(SETTLE_CYCLES));
    sample      = (state == S_RUN) && settle_last;
    last_vec    = (idx == LAST_IDX);
    mismatch    = (out_resultado != cur_vec.res) || (zero != cur_vec.zf) ||
                  (cur_vec.chk_flags && ((carry_out != cur_vec.cf) || (overflow != cur_vec.vf)));
  end

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      a              <= '0;
      b              <= '0;
      alu_control    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= NO_FAIL;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      settle_cnt     <= settle_cnt_d;
      a              <= a_d;
      b              <= b_d;
      alu_control    <= alu_control_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      fail_count     <= fail_count_d;
      first_fail_idx <= first_fail_idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (sample && (last_vec || (STOP_ON_FAIL && mismatch))) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    idx_d            = idx;
    settle_cnt_d     = settle_cnt;
    a_d              = a;
    b_d              = b;
    alu_control_d    = alu_control;
    busy_d           = busy;
    done_d           = 1'b0;
    pass_d           = pass;
    fail_count_d     = fail_count;
    first_fail_idx_d = first_fail_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_d            = '0;
          settle_cnt_d     = CNT_W'(1);
          a_d              = first_vec.op_a;
          b_d              = first_vec.op_b;
          alu_control_d    = first_vec.op;
          busy_d           = 1'b1;
          fail_count_d     = '0;
          first_fail_idx_d = NO_FAIL;
        end
      end
      S_RUN: begin
        if (sample) begin
          if (mismatch) begin
            fail_count_d = (fail_count == CNT_MAX) ? CNT_MAX : 4'(fail_count + 4'd1);
            if (first_fail_idx == NO_FAIL) first_fail_idx_d = idx;
          end
          if (state_d == S_FINISH) begin
            a_d           = '0;
            b_d           = '0;
            alu_control_d = '0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            pass_d        = (fail_count_d == 4'd0);
          end else begin
            idx_d         = IDX_W'(idx + 4'd1);
            settle_cnt_d  = CNT_W'(1);
            a_d           = nxt_vec.op_a;
            b_d           = nxt_vec.op_b;
            alu_control_d = nxt_vec.op;
          end
        end else begin
          settle_cnt_d = CNT_W'(settle_cnt + CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: three instances (S=1, S=3, stop-on-fail) each fed by a
// behavioural ALU with selectable fault injection.
module tb_alu_bist;

  logic        clk;
  logic        rst_w   [3];
  logic        start_w [3];
  logic [31:0] a_w     [3];
  logic [31:0] b_w     [3];
  logic [3:0]  ctl_w   [3];
  logic [31:0] res_w   [3];
  logic        zr_w    [3];
  logic        cy_w    [3];
  logic        ov_w    [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        pass_w  [3];
  logic [3:0]  fail_w  [3];
  logic [3:0]  ffi_w   [3];
  int          mode_w  [3];

  int total = 0;
  int bad   = 0;

  logic        cap_busy [0:63];
  logic        cap_done [0:63];
  logic        cap_pass [0:63];
  logic [31:0] cap_a    [0:63];
  logic [3:0]  cap_ctl  [0:63];
  logic [3:0]  cap_fail [0:63];

  // mode: 0 good, 1 SUB->0, 2 carry stuck 0, 3 carry=1 on AND/OR, 4 NOR->all ones, 5 AND inverted
  function automatic logic [34:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [3:0] op, input int mode);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0];
        c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      4'b0110: r = x - y;
      4'b0111: r = {31'b0, ($signed(x) < $signed(y))};
      4'b1100: r = ~(x | y);
      default: r = '0;
    endcase
    if (mode == 1 && op == 4'b0110) r = '0;
    if (mode == 2 && op == 4'b0010) c = 1'b0;
    if (mode == 3 && (op == 4'b0000 || op == 4'b0001)) c = 1'b1;
    if (mode == 4 && op == 4'b1100) r = 32'hFFFFFFFF;
    if (mode == 5 && op == 4'b0000) r = ~r;
    return {v, c, (r == 32'd0), r};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_alu
    assign {ov_w[g], cy_w[g], zr_w[g], res_w[g]} = alu_model(a_w[g], b_w[g], ctl_w[g], mode_w[g]);
  end

  alu_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .reset(rst_w[0]), .start(start_w[0]), .a(a_w[0]), .b(b_w[0]),
    .alu_control(ctl_w[0]), .out_resultado(res_w[0]), .zero(zr_w[0]), .carry_out(cy_w[0]),
    .overflow(ov_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_count(fail_w[0]), .first_fail_idx(ffi_w[0]));

  alu_bist #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1'b0)) dut_s3 (
    .clk(clk), .reset(rst_w[1]), .start(start_w[1]), .a(a_w[1]), .b(b_w[1]),
    .alu_control(ctl_w[1]), .out_resultado(res_w[1]), .zero(zr_w[1]), .carry_out(cy_w[1]),
    .overflow(ov_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_count(fail_w[1]), .first_fail_idx(ffi_w[1]));

  alu_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) dut_sof (
    .clk(clk), .reset(rst_w[2]), .start(start_w[2]), .a(a_w[2]), .b(b_w[2]),
    .alu_control(ctl_w[2]), .out_resultado(res_w[2]), .zero(zr_w[2]), .carry_out(cy_w[2]),
    .overflow(ov_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .fail_count(fail_w[2]), .first_fail_idx(ffi_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a run on one instance (C0 is the cycle start is first sampled) and log C1..C(ncyc).
  // start stays high in cycles hold_lo..hold_hi.
  task automatic run_capture(input int inst, input int ncyc, input int hold_lo, input int hold_hi,
                             output int done_cyc, output int done_cnt);
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    start_w[inst] = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cap_busy[c] = busy_w[inst];
      cap_done[c] = done_w[inst];
      cap_pass[c] = pass_w[inst];
      cap_a[c]    = a_w[inst];
      cap_ctl[c]  = ctl_w[inst];
      cap_fail[c] = fail_w[inst];
      if (done_w[inst]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      start_w[inst] = (c >= hold_lo && c <= hold_hi);
    end
    start_w[inst] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      total++; if (busy_w[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", i, busy_w[i]); end
      total++; if (done_w[i] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d] got=%b want=0", i, done_w[i]); end
      total++; if (pass_w[i] !== 1'b0) begin bad++; $display("FAIL reset_pass[%0d] got=%b want=0", i, pass_w[i]); end
      total++; if (a_w[i] !== 32'd0 || b_w[i] !== 32'd0 || ctl_w[i] !== 4'd0) begin
        bad++; $display("FAIL reset_operands[%0d] got=%h/%h/%h want=0", i, a_w[i], b_w[i], ctl_w[i]); end
      total++; if (fail_w[i] !== 4'd0) begin bad++; $display("FAIL reset_fail_count[%0d] got=%0d want=0", i, fail_w[i]); end
      total++; if (ffi_w[i] !== 4'hF) begin bad++; $display("FAIL reset_first_fail[%0d] got=%h want=f", i, ffi_w[i]); end
    end
  endtask

  task automatic test_good_s1;
    int dc, dn;
    mode_w[0] = 0;
    run_capture(0, 14, 0, 0, dc, dn);
    total++; if (dc !== 11) begin bad++; $display("FAIL good_done_cycle got=%0d want=11", dc); end
    total++; if (cap_busy[1] !== 1'b1 || cap_busy[10] !== 1'b1 || cap_busy[11] !== 1'b0) begin
      bad++; $display("FAIL good_busy_window got=%b%b%b want=110", cap_busy[1], cap_busy[10], cap_busy[11]); end
    total++; if (cap_a[1] !== 32'hFFFF0000 || cap_ctl[1] !== 4'b0000) begin
      bad++; $display("FAIL good_vec0 got=%h/%h want=ffff0000/0", cap_a[1], cap_ctl[1]); end
    total++; if (cap_a[4] !== 32'h7FFFFFFF || cap_ctl[4] !== 4'b0010) begin
      bad++; $display("FAIL good_vec3 got=%h/%h want=7fffffff/2", cap_a[4], cap_ctl[4]); end
    total++; if (cap_ctl[10] !== 4'b1100) begin bad++; $display("FAIL good_vec9_op got=%h want=c", cap_ctl[10]); end
    total++; if (cap_a[11] !== 32'd0 || cap_ctl[11] !== 4'd0) begin
      bad++; $display("FAIL good_finish_operands got=%h/%h want=0", cap_a[11], cap_ctl[11]); end
    total++; if (pass_w[0] !== 1'b1) begin bad++; $display("FAIL good_pass got=%b want=1", pass_w[0]); end
    total++; if (fail_w[0] !== 4'd0) begin bad++; $display("FAIL good_fail_count got=%0d want=0", fail_w[0]); end
    total++; if (ffi_w[0] !== 4'hF) begin bad++; $display("FAIL good_first_fail got=%h want=f", ffi_w[0]); end
  endtask

  task automatic test_sub_fault;
    int dc, dn;
    mode_w[0] = 1;
    run_capture(0, 14, 0, 0, dc, dn);
    total++; if (dc !== 11) begin bad++; $display("FAIL sub_done_cycle got=%0d want=11", dc); end
    total++; if (cap_pass[5] !== 1'b1) begin bad++; $display("FAIL sub_pass_hold got=%b want=1", cap_pass[5]); end
    total++; if (pass_w[0] !== 1'b0) begin bad++; $display("FAIL sub_pass got=%b want=0", pass_w[0]); end
    total++; if (fail_w[0] !== 4'd2) begin bad++; $display("FAIL sub_fail_count got=%0d want=2", fail_w[0]); end
    total++; if (ffi_w[0] !== 4'd5) begin bad++; $display("FAIL sub_first_fail got=%0d want=5", ffi_w[0]); end
  endtask

  task automatic test_carry;
    int dc, dn;
    mode_w[0] = 2;
    run_capture(0, 14, 0, 0, dc, dn);
    total++; if (cap_fail[1] !== 4'd0) begin bad++; $display("FAIL carry_count_cleared got=%0d want=0", cap_fail[1]); end
    total++; if (fail_w[0] !== 4'd1) begin bad++; $display("FAIL carry0_fail_count got=%0d want=1", fail_w[0]); end
    total++; if (ffi_w[0] !== 4'd4) begin bad++; $display("FAIL carry0_first_fail got=%0d want=4", ffi_w[0]); end
    total++; if (pass_w[0] !== 1'b0) begin bad++; $display("FAIL carry0_pass got=%b want=0", pass_w[0]); end
    mode_w[0] = 3;
    run_capture(0, 14, 0, 0, dc, dn);
    total++; if (cap_pass[5] !== 1'b0) begin bad++; $display("FAIL carry1_pass_hold got=%b want=0", cap_pass[5]); end
    total++; if (pass_w[0] !== 1'b1 || fail_w[0] !== 4'd0) begin
      bad++; $display("FAIL carry1_dont_care got=pass%b/cnt%0d want=pass1/cnt0", pass_w[0], fail_w[0]); end
    total++; if (ffi_w[0] !== 4'hF) begin bad++; $display("FAIL carry1_first_fail got=%h want=f", ffi_w[0]); end
  endtask

  task automatic test_stop_on_fail;
    int dc, dn;
    mode_w[2] = 4;
    run_capture(2, 14, 0, 0, dc, dn);
    total++; if (dc !== 11) begin bad++; $display("FAIL sof_nor_done_cycle got=%0d want=11", dc); end
    total++; if (ffi_w[2] !== 4'd9 || fail_w[2] !== 4'd1) begin
      bad++; $display("FAIL sof_nor_result got=idx%0d/cnt%0d want=idx9/cnt1", ffi_w[2], fail_w[2]); end
    mode_w[2] = 5;
    run_capture(2, 14, 0, 0, dc, dn);
    total++; if (dc !== 2) begin bad++; $display("FAIL sof_and_done_cycle got=%0d want=2", dc); end
    total++; if (cap_busy[2] !== 1'b0 || cap_busy[3] !== 1'b0) begin
      bad++; $display("FAIL sof_and_busy got=%b%b want=00", cap_busy[2], cap_busy[3]); end
    total++; if (fail_w[2] !== 4'd1 || ffi_w[2] !== 4'd0 || pass_w[2] !== 1'b0) begin
      bad++; $display("FAIL sof_and_result got=cnt%0d/idx%0d/pass%b want=cnt1/idx0/pass0",
                      fail_w[2], ffi_w[2], pass_w[2]); end
  endtask

  task automatic test_settle3;
    int dc, dn;
    mode_w[1] = 0;
    run_capture(1, 40, 5, 8, dc, dn);
    total++; if (dc !== 31) begin bad++; $display("FAIL s3_done_cycle got=%0d want=31", dc); end
    total++; if (dn !== 1) begin bad++; $display("FAIL s3_start_ignored got=%0d dones want=1", dn); end
    total++; if (cap_ctl[3] !== 4'b0000 || cap_ctl[4] !== 4'b0001 || cap_ctl[6] !== 4'b0001 || cap_ctl[7] !== 4'b0010) begin
      bad++; $display("FAIL s3_hold got=%h%h%h%h want=0112", cap_ctl[3], cap_ctl[4], cap_ctl[6], cap_ctl[7]); end
    total++; if (cap_a[9] !== 32'd100 || cap_a[10] !== 32'h7FFFFFFF) begin
      bad++; $display("FAIL s3_operands got=%h/%h want=64/7fffffff", cap_a[9], cap_a[10]); end
    total++; if (cap_busy[30] !== 1'b1 || cap_busy[31] !== 1'b0 || cap_busy[35] !== 1'b0) begin
      bad++; $display("FAIL s3_busy got=%b%b%b want=100", cap_busy[30], cap_busy[31], cap_busy[35]); end
    total++; if (pass_w[1] !== 1'b1 || fail_w[1] !== 4'd0) begin
      bad++; $display("FAIL s3_pass got=pass%b/cnt%0d want=pass1/cnt0", pass_w[1], fail_w[1]); end
  endtask

  task automatic test_back_to_back;
    int dc, dn;
    mode_w[0] = 0;
    run_capture(0, 30, 1, 22, dc, dn);
    total++; if (dc !== 11 || cap_done[23] !== 1'b1 || dn !== 2) begin
      bad++; $display("FAIL b2b_dones got=first%0d/c23=%b/n%0d want=first11/c23=1/n2", dc, cap_done[23], dn); end
    total++; if (cap_busy[12] !== 1'b0 || cap_busy[13] !== 1'b1 || cap_busy[25] !== 1'b0) begin
      bad++; $display("FAIL b2b_busy got=%b%b%b want=010", cap_busy[12], cap_busy[13], cap_busy[25]); end
  endtask

  task automatic test_reset_abort;
    int dc, dn, late_done;
    mode_w[0] = 1;
    late_done = 0;
    @(negedge clk);
    start_w[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_w[0] = 1'b0;
      if (c == 4) rst_w[0] = 1'b1;
      if (c == 5) begin
        rst_w[0] = 1'b0;
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_w[0]); end
        total++; if (a_w[0] !== 32'd0 || b_w[0] !== 32'd0 || ctl_w[0] !== 4'd0) begin
          bad++; $display("FAIL abort_operands got=%h/%h/%h want=0", a_w[0], b_w[0], ctl_w[0]); end
        total++; if (ffi_w[0] !== 4'hF || fail_w[0] !== 4'd0 || pass_w[0] !== 1'b0) begin
          bad++; $display("FAIL abort_status got=idx%h/cnt%0d/pass%b want=idxf/cnt0/pass0",
                          ffi_w[0], fail_w[0], pass_w[0]); end
      end
      if (c >= 5 && done_w[0]) late_done++;
    end
    total++; if (late_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", late_done); end
    mode_w[0] = 0;
    run_capture(0, 14, 0, 0, dc, dn);
    total++; if (dc !== 11 || pass_w[0] !== 1'b1 || ffi_w[0] !== 4'hF) begin
      bad++; $display("FAIL abort_rerun got=done%0d/pass%b/idx%h want=done11/pass1/idxf", dc, pass_w[0], ffi_w[0]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_w[i]   = 1'b1;
      start_w[i] = 1'b0;
      mode_w[i]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_w[i] = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_s1();
    test_sub_fault();
    test_carry();
    test_stop_on_fail();
    test_settle3();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
